flex_bank_router: RTL and testbench



---
 rtl/flex_bank_router.sv | 95 +++++++++
 tb/tb_flex_bank_router.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_bank_router.sv
// Registered address/strobe router from one host port to NUM_BANK single-port SRAM banks,
// with broadcast writes and an in-order read-return pipeline matched to the bank latency.
module flex_bank_router #(
  parameter int NUM_BANK = 4,
  parameter int SEL_W    = $clog2(NUM_BANK),
  parameter int BANK_AW  = 4,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iCsn,
  input  logic                     iWrn,
  input  logic                     iBcast,
  input  logic [SEL_W+BANK_AW-1:0] iAddr,
  input  logic [DW-1:0]            iWrDt,
  output logic [BANK_AW-1:0]       oAddr,
  output logic [DW-1:0]            oWrDt,
  output logic [NUM_BANK-1:0]      oCsn,
  output logic [NUM_BANK-1:0]      oWrn,
  input  logic [NUM_BANK*DW-1:0]   iRdDt,
  output logic [DW-1:0]            oRdDt,
  output logic                     oRdVld
);

  localparam int AW     = SEL_W + BANK_AW;
  localparam int PIPE_D = RD_LAT + 1;

  logic [SEL_W-1:0]    sel;
  logic                req_wr;
  logic                req_rd;
  logic                bcast_wr;
  logic [NUM_BANK-1:0] hit;
  logic [NUM_BANK-1:0] csn_d;
  logic [NUM_BANK-1:0] wrn_d;
  logic [DW-1:0]       rd_word [NUM_BANK];

  assign sel      = iAddr[AW-1 -: SEL_W];
  assign req_wr   = ~iCsn & ~iWrn;
  assign req_rd   = ~iCsn & iWrn;
  // Broadcast only applies to writes; a read with iBcast set is an ordinary read.
  assign bcast_wr = req_wr & iBcast;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
      assign hit[gi]     = (sel == SEL_W'(gi));
      assign csn_d[gi]   = ~(bcast_wr | (~iCsn & hit[gi]));
      assign wrn_d[gi]   = ~(bcast_wr | (req_wr & hit[gi]));
      assign rd_word[gi] = iRdDt[gi*DW +: DW];
    end
  endgenerate

  logic [NUM_BANK-1:0] csn_q;
  logic [NUM_BANK-1:0] wrn_q;
  logic [BANK_AW-1:0]  addr_q;
  logic [DW-1:0]       wrdt_q;
  logic [DW-1:0]       rddt_q;
  logic                rdvld_q;
  logic [PIPE_D-1:0]   pv_q;
  logic [SEL_W-1:0]    ps_q [PIPE_D];

  // Stage i of {pv_q, ps_q} describes a read issued i+1 cycles ago; the tail stage
  // lines up with the cycle in which the bank drives iRdDt.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      csn_q   <= '1;
      wrn_q   <= '1;
      addr_q  <= '0;
      wrdt_q  <= '0;
      rddt_q  <= '0;
      rdvld_q <= 1'b0;
      pv_q    <= '0;
      for (int i = 0; i < PIPE_D; i++) ps_q[i] <= '0;
    end else begin
      csn_q <= csn_d;
      wrn_q <= wrn_d;
      if (!iCsn) addr_q <= iAddr[BANK_AW-1:0];
      if (req_wr) wrdt_q <= iWrDt;
      pv_q    <= {pv_q[PIPE_D-2:0], req_rd};
      ps_q[0] <= sel;
      for (int i = 1; i < PIPE_D; i++) ps_q[i] <= ps_q[i-1];
      rdvld_q <= pv_q[RD_LAT];
      if (pv_q[RD_LAT]) rddt_q <= rd_word[ps_q[RD_LAT]];
    end
  end

  assign oCsn   = csn_q;
  assign oWrn   = wrn_q;
  assign oAddr  = addr_q;
  assign oWrDt  = wrdt_q;
  assign oRdDt  = rddt_q;
  assign oRdVld = rdvld_q;

endmodule

// File: tb/tb_flex_bank_router.sv
// Directed bench for flex_bank_router: one RD_LAT=1 and one RD_LAT=2 instance share the
// host inputs, each backed by behavioural SRAM bank models preloaded with known words.
module tb_flex_bank_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csn = 1'b1;
  logic        wrn = 1'b1;
  logic        bcast = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] wrdt = '0;

  logic [3:0]  oaddr1, oaddr2;
  logic [15:0] owrdt1, owrdt2;
  logic [3:0]  ocsn1, ocsn2, owrn1, owrn2;
  logic [63:0] irddt1, irddt2;
  logic [15:0] ordt1, ordt2;
  logic        vld1, vld2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  flex_bank_router #(.RD_LAT(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iCsn(csn), .iWrn(wrn), .iBcast(bcast), .iAddr(addr),
    .iWrDt(wrdt), .oAddr(oaddr1), .oWrDt(owrdt1), .oCsn(ocsn1), .oWrn(owrn1),
    .iRdDt(irddt1), .oRdDt(ordt1), .oRdVld(vld1)
  );

  flex_bank_router #(.RD_LAT(2)) u_dut2 (
    .iClk(clk), .iRst(rst), .iCsn(csn), .iWrn(wrn), .iBcast(bcast), .iAddr(addr),
    .iWrDt(wrdt), .oAddr(oaddr2), .oWrDt(owrdt2), .oCsn(ocsn2), .oWrn(owrn2),
    .iRdDt(irddt2), .oRdDt(ordt2), .oRdVld(vld2)
  );

  // Bank k word a starts as 16'h1000*(k+1) + a.
  logic [15:0] mem1 [4][16];
  logic [15:0] mem2 [4][16];
  logic [15:0] r1 [4];
  logic [15:0] r2a [4];
  logic [15:0] r2b [4];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 4; k++)
        for (int a = 0; a < 16; a++) begin
          mem1[k][a] <= 16'((k + 1) * 4096 + a);
          mem2[k][a] <= 16'((k + 1) * 4096 + a);
        end
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!ocsn1[k]) begin
          if (!owrn1[k]) mem1[k][oaddr1] <= owrdt1;
          else           r1[k] <= mem1[k][oaddr1];
        end
        if (!ocsn2[k]) begin
          if (!owrn2[k]) mem2[k][oaddr2] <= owrdt2;
          else           r2a[k] <= mem2[k][oaddr2];
        end
        r2b[k] <= r2a[k];
      end
    end
  end

  assign irddt1 = {r1[3], r1[2], r1[1], r1[0]};
  assign irddt2 = {r2b[3], r2b[2], r2b[1], r2b[0]};

  task automatic drive(input logic c, input logic w, input logic b,
                       input logic [5:0] a, input logic [15:0] d);
    csn = c; wrn = w; bcast = b; addr = a; wrdt = d;
    if (!c) $display("[TB] t=%0t %s bcast=%0b addr=%h data=%h", $time, w ? "RD" : "WR", b, a, d);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, 6'h00, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 6'h25, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({ocsn1, owrn1, oaddr1, vld1} !== {4'b1111, 4'b1111, 4'h0, 1'b0}) begin
        failed++;
        $display("FAIL reset_strobes cyc%0d: csn=%b wrn=%b addr=%h vld=%b, need 1111 1111 0 0",
                 i, ocsn1, owrn1, oaddr1, vld1);
      end
      tests++;
      if ({owrdt1, ordt1, vld2} !== {16'h0000, 16'h0000, 1'b0}) begin
        failed++;
        $display("FAIL reset_data cyc%0d: wrdt=%h rddt=%h vld2=%b, need 0 0 0", i, owrdt1, ordt1, vld2);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [5:0]  a_t [4];
    logic [15:0] d_t [4];
    logic [3:0]  e_t [4];
    a_t = '{6'h05, 6'h15, 6'h25, 6'h35};
    d_t = '{16'h0A05, 16'h1B15, 16'hBEEF, 16'h3D35};
    e_t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, a_t[k], d_t[k]);
      tick();
      tests++;
      if ({ocsn1, owrn1, oaddr1, owrdt1} !== {e_t[k], e_t[k], 4'h5, d_t[k]}) begin
        failed++;
        $display("FAIL decode_bank%0d: csn=%b wrn=%b addr=%h wrdt=%h, need %b %b 5 %h",
                 k, ocsn1, owrn1, oaddr1, owrdt1, e_t[k], e_t[k], d_t[k]);
      end
    end
    idle();
    tick();
    tests++;
    if ({ocsn1, owrn1, oaddr1, owrdt1} !== {4'b1111, 4'b1111, 4'h5, 16'h3D35}) begin
      failed++;
      $display("FAIL decode_idle: csn=%b wrn=%b addr=%h wrdt=%h, need 1111 1111 5 3d35",
               ocsn1, owrn1, oaddr1, owrdt1);
    end
    tests++;
    if ({ocsn2, owrn2, vld1} !== {4'b1111, 4'b1111, 1'b0}) begin
      failed++;
      $display("FAIL decode_idle_dut2: csn=%b wrn=%b vld1=%b, need 1111 1111 0", ocsn2, owrn2, vld1);
    end
    drain();
  endtask

  task automatic test_broadcast();
    drive(1'b0, 1'b0, 1'b1, 6'h3A, 16'h1234);
    tick();
    tests++;
    if ({ocsn1, owrn1, oaddr1, owrdt1} !== {4'b0000, 4'b0000, 4'hA, 16'h1234}) begin
      failed++;
      $display("FAIL bcast_write: csn=%b wrn=%b addr=%h wrdt=%h, need 0000 0000 a 1234",
               ocsn1, owrn1, oaddr1, owrdt1);
    end
    drive(1'b0, 1'b1, 1'b1, 6'h3A, 16'h0000);
    tick();
    tests++;
    if ({ocsn1, owrn1, oaddr1} !== {4'b0111, 4'b1111, 4'hA}) begin
      failed++;
      $display("FAIL bcast_read: csn=%b wrn=%b addr=%h, need 0111 1111 a", ocsn1, owrn1, oaddr1);
    end
    idle();
    tick();
    tests++;
    if (vld1 !== 1'b0) begin
      failed++;
      $display("FAIL bcast_read_early: vld=%b, need 0", vld1);
    end
    tick();
    tests++;
    if ({vld1, ordt1} !== {1'b1, 16'h1234}) begin
      failed++;
      $display("FAIL bcast_read_return: vld=%b data=%h, need 1 1234", vld1, ordt1);
    end
    tick();
    tests++;
    if (vld1 !== 1'b0) begin
      failed++;
      $display("FAIL bcast_read_single_pulse: vld=%b, need 0", vld1);
    end
    drain();
  endtask

  task automatic test_read_stream();
    logic        c_t [5];
    logic        w_t [5];
    logic [5:0]  a_t [5];
    logic [15:0] d_t [5];
    logic        ev [11];
    logic [15:0] ed [11];
    c_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    w_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    a_t = '{6'h01, 6'h11, 6'h07, 6'h21, 6'h31};
    d_t = '{16'h0, 16'h0, 16'hCAFE, 16'h0, 16'h0};
    for (int i = 0; i < 11; i++) begin ev[i] = 1'b0; ed[i] = 16'h0; end
    ev[3] = 1'b1; ed[3] = 16'h1001;
    ev[4] = 1'b1; ed[4] = 16'h2001;
    ev[6] = 1'b1; ed[6] = 16'h3001;
    ev[7] = 1'b1; ed[7] = 16'h4001;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) drive(c_t[c], w_t[c], 1'b0, a_t[c], d_t[c]);
      else idle();
      tick();
      tests++;
      if (vld1 !== ev[c+1] || (ev[c+1] && ordt1 !== ed[c+1])) begin
        failed++;
        $display("FAIL stream_cyc%0d: vld=%b data=%h, need vld=%b data=%h",
                 c + 1, vld1, ordt1, ev[c+1], ed[c+1]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  a_t [4];
    logic        ev [9];
    logic [15:0] ed [9];
    a_t = '{6'h0A, 6'h1A, 6'h2A, 6'h07};
    for (int i = 0; i < 9; i++) begin ev[i] = 1'b0; ed[i] = 16'h0; end
    ev[3] = 1'b1; ed[3] = 16'h1234;
    ev[4] = 1'b1; ed[4] = 16'h1234;
    ev[5] = 1'b1; ed[5] = 16'h1234;
    ev[6] = 1'b1; ed[6] = 16'hCAFE;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b0, 1'b1, 1'b0, a_t[c], 16'h0);
      else idle();
      tick();
      tests++;
      if (vld1 !== ev[c+1] || (ev[c+1] && ordt1 !== ed[c+1])) begin
        failed++;
        $display("FAIL b2b_cyc%0d: vld=%b data=%h, need vld=%b data=%h",
                 c + 1, vld1, ordt1, ev[c+1], ed[c+1]);
      end
    end
    drain();
  endtask

  task automatic test_rdlat2();
    drive(1'b0, 1'b1, 1'b0, 6'h2F, 16'h0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      idle();
      tests++;
      if (vld2 !== (c == 4) || (c == 4 && ordt2 !== 16'h300F)) begin
        failed++;
        $display("FAIL rdlat2_cyc%0d: vld=%b data=%h, need vld=%b data=300f",
                 c, vld2, ordt2, (c == 4));
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, 1'b1, 1'b0, 6'h01, 16'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 6'h11, 16'h0);
    tick();
    rst = 1'b0;
    idle();
    tests++;
    if ({ocsn1, ocsn2, oaddr1} !== {4'b1111, 4'b1111, 4'h0}) begin
      failed++;
      $display("FAIL midrst_strobes: csn1=%b csn2=%b addr=%h, need 1111 1111 0", ocsn1, ocsn2, oaddr1);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++;
      if ({vld1, vld2} !== 2'b00) begin
        failed++;
        $display("FAIL midrst_no_vld_cyc%0d: vld1=%b vld2=%b, need 0 0", c, vld1, vld2);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 6'h13, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      idle();
      tests++;
      if (vld1 !== (c == 3) || (c == 3 && ordt1 !== 16'h2003)) begin
        failed++;
        $display("FAIL midrst_fresh1_cyc%0d: vld=%b data=%h, need vld=%b data=2003",
                 c, vld1, ordt1, (c == 3));
      end
      tests++;
      if (vld2 !== (c == 4) || (c == 4 && ordt2 !== 16'h2003)) begin
        failed++;
        $display("FAIL midrst_fresh2_cyc%0d: vld=%b data=%h, need vld=%b data=2003",
                 c, vld2, ordt2, (c == 4));
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_broadcast();
    test_read_stream();
    test_back_to_back();
    test_rdlat2();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
